// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and negate helper for the iterative RV32M mul/div unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // Wide enough for the 2*XLEN product at XLEN=64; callers zero-extend and cast back down.
    localparam int NEG_W = 128;

    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core (master) and the mul/div unit (slave).
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, kill, funct3, op_a, op_b,
                    input  busy, done, result);
    modport slave  (input  start, kill, funct3, op_a, op_b,
                    output busy, done, result);
endinterface

// File: rtl/muldiv_sign_fix.sv
// FIX stage: restore signs on the magnitude results, apply RISC-V special cases, select the result.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   rem,
    input  logic              neg_a,
    input  logic              neg_b,
    input  logic              div0,
    input  logic              ovf,
    output logic [XLEN-1:0]   result
);
    localparam int PW = 2 * XLEN;

    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? PW'(twos_neg(NEG_W'(prod))) : prod;

        if (div0)
            quo_fix = '1;
        else if (ovf)
            quo_fix = {1'b1, {(XLEN-1){1'b0}}};
        else
            quo_fix = (neg_a ^ neg_b) ? XLEN'(twos_neg(NEG_W'(quo))) : quo;

        // Divide-by-zero needs no override: the iteration leaves |dividend| as remainder.
        if (ovf)
            rem_fix = '0;
        else
            rem_fix = neg_a ? XLEN'(twos_neg(NEG_W'(rem))) : rem;

        case (funct3)
            F3_MUL:                      result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[PW-1:XLEN];
            F3_DIV, F3_DIVU:             result = quo_fix;
            default:                     result = rem_fix;
        endcase
    end
endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide, one bit per cycle. Define MULDIV_FASTPATH_EN to
// finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | XLEN shift-add / restoring-divide iterations on magnitudes
// S_FIX  | sign restore, special cases, result register load
// S_DONE | done pulse; a new start is accepted here
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int              CW       = $clog2(XLEN) + 1;
    localparam int              PW       = 2 * XLEN;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    state_t          state, state_nxt;
    logic            accept;
    logic            fast;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] mag_a, mag_b, quo, rem, result_q, fix_result;
    logic [PW-1:0]   prod;
    logic            neg_a, neg_b, div0, ovf;

    logic            in_neg_a, in_neg_b, in_div0, in_ovf;
    logic [XLEN-1:0] in_mag_a, in_mag_b;
    logic [XLEN:0]   mul_sum, partial, trial;

    assign in_neg_a = signed_a(bus.funct3) & bus.op_a[XLEN-1];
    assign in_neg_b = signed_b(bus.funct3) & bus.op_b[XLEN-1];
    assign in_mag_a = in_neg_a ? XLEN'(twos_neg(NEG_W'(bus.op_a))) : bus.op_a;
    assign in_mag_b = in_neg_b ? XLEN'(twos_neg(NEG_W'(bus.op_b))) : bus.op_b;
    assign in_div0  = bus.funct3[2] & (bus.op_b == '0);
    assign in_ovf   = bus.funct3[2] & ~bus.funct3[0]
                    & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);

`ifdef MULDIV_FASTPATH_EN
    logic [XLEN-1:0] fast_result;
    assign fast = in_div0 | in_ovf
                | (~bus.funct3[2] & ((bus.op_a == '0) | (bus.op_b == '0)));
    // funct3[1] separates REM/REMU from DIV/DIVU; zero-operand multiplies yield 0.
    assign fast_result = in_div0 ? (bus.funct3[1] ? bus.op_a : '1)
                       : in_ovf  ? (bus.funct3[1] ? '0 : bus.op_a)
                       : '0;
`else
    assign fast = 1'b0;
`endif

    assign mul_sum = {1'b0, prod[PW-1:XLEN]} + {1'b0, mag_a};
    assign partial = {rem, quo[XLEN-1]};
    assign trial   = partial - {1'b0, mag_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                bus.done  = (state == S_DONE);
                state_nxt = S_IDLE;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                bus.busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = S_FIX;
            end
            S_FIX: begin
                bus.busy  = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.kill) begin
            accept    = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
            prod     <= '0;
            quo      <= '0;
            rem      <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= bus.funct3;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            div0  <= in_div0;
            ovf   <= in_ovf;
            prod  <= {{XLEN{1'b0}}, in_mag_b};
            quo   <= in_mag_a;
            rem   <= '0;
`ifdef MULDIV_FASTPATH_EN
            if (fast) result_q <= fast_result;
`endif
        end else if (!bus.kill) begin
            if (state == S_CALC) begin
                cnt <= cnt + CW'(1);
                if (op_q[2]) begin
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= partial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    prod <= prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[PW-1:1]};
                end
            end else if (state == S_FIX) begin
                result_q <= fix_result;
            end
        end
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .funct3 (op_q),
        .prod   (prod),
        .quo    (quo),
        .rem    (rem),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .div0   (div0),
        .ovf    (ovf),
        .result (fix_result)
    );

    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed-vector bench for muldiv_iter_unit; cycle 1 is the first cycle after the start edge.
module tb_muldiv_iter_unit;
    import muldiv_pkg::*;

    localparam int LAT = 34;
`ifdef MULDIV_FASTPATH_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   overlap = 0;
    int   lat, bc;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_iter_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = 32'hDEAD_BEEF;
        bus.op_b  = 32'h0000_0001;
    endtask

    // Returns the cycle index of the done pulse, or -1 if none within 100 cycles.
    task automatic wait_done(input int first, output int lat_o, output int busy_o);
        lat_o  = -1;
        busy_o = 0;
        for (int n = first + 1; n <= first + 100; n++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap++;
            if (bus.busy) busy_o++;
            if (bus.done) begin
                lat_o = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int l, nb;
        launch(f3, a, b);
        wait_done(0, l, nb);
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check({tag, "_busy"}, 32'(nb), 32'(exp_lat - 1));
        @(negedge clk);
        check({tag, "_pulse"}, {30'b0, bus.busy, bus.done}, 32'h0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_result", bus.result, 32'h0);
        rst_n = 1'b1;

        run_op("mul_neg",     F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
        run_op("mulhu_ones",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        run_op("mulh_ones",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT);
        run_op("mulhsu",      F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT);
        run_op("mul_2p32",    F3_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, LAT);
        run_op("mulhu_2p32",  F3_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT);
        run_op("mul_zero",    F3_MUL,    32'h1234_5678, 32'h0000_0000, 32'h0000_0000, SPEC_LAT);
        run_op("mulhu_zero",  F3_MULHU,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
        run_op("div_neg7",    F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT);
        run_op("rem_neg7",    F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT);
        run_op("div_7_m2",    F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
        run_op("rem_7_m2",    F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT);
        run_op("div_ovf",     F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        run_op("rem_ovf",     F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
        run_op("divu_big",    F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT);
        run_op("remu_big",    F3_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT);
        run_op("divu_zero",   F3_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("remu_zero",   F3_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPEC_LAT);
        run_op("div_zero_n",  F3_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("rem_zero_n",  F3_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, SPEC_LAT);
        run_op("divu_100_7",  F3_DIVU,   32'd100,       32'd7,         32'd14,        LAT);
        run_op("remu_100_7",  F3_REMU,   32'd100,       32'd7,         32'd2,         LAT);

        // start pulsed in cycle 5 of a busy operation must be ignored
        launch(F3_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd3;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(5, lat, bc);
        check("ign_res", bus.result, 32'd14);
        check("ign_lat", 32'(lat), 32'd34);
        @(negedge clk);
        check("ign_idle", {30'b0, bus.busy, bus.done}, 32'h0);

        // kill in cycle 10: idle in cycle 11, no done, result kept
        launch(F3_MUL, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'b0, bus.busy}, 32'h0);
        wait_done(11, lat, bc);
        check("kill_nodone", 32'(lat), 32'hFFFF_FFFF);
        check("kill_result", bus.result, 32'd14);

        // kill beats a simultaneous start
        @(negedge clk);
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd5;
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(negedge clk);
        check("kill_vs_start", {30'b0, bus.busy, bus.done}, 32'h0);

        // asynchronous reset in cycle 20 of a DIV
        launch(F3_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (20) @(negedge clk);
        check("rst_pre_busy", {31'b0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_mid_done", {31'b0, bus.done}, 32'h0);
        check("rst_mid_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // start in the DONE cycle is accepted
        launch(F3_DIVU, 32'd100, 32'd7);
        wait_done(0, lat, bc);
        check("b2b_first", bus.result, 32'd14);
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd6;
        bus.op_b   = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(0, lat, bc);
        check("b2b_res", bus.result, 32'd42);
        check("b2b_lat", 32'(lat), 32'd34);

        check("busy_done_excl", 32'(overlap), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
